gpio_input_ctrl: RTL and testbench

Input-direction companion to the seven-segment output path: the core-to-board path pushes writeback words out to the display, and this block carries board inputs back toward the core.
- Synchronizes and debounces the slide switches and push buttons.
- On each debounced button press, captures an event word (switch snapshot plus press mask) into a small FIFO.
- Presents the FIFO head to the consumer with a valid/ready handshake.
- Runs on the board clock; the consumer samples it through the handshake only.

---
 rtl/gpio_in_pkg.sv | 20 ++
 rtl/debounce_cell.sv | 52 +++++
 rtl/gpio_input_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gpio_input_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// Shared definitions for the board-input path: event word layout and its packed view.
// The event word carries a switch snapshot in the upper half and the press mask in the low bits.
package gpio_in_pkg;

    localparam int unsigned EVT_WORD_W   = 32;
    localparam int unsigned EVT_SW_MSB   = 31;
    localparam int unsigned EVT_SW_LSB   = 16;
    localparam int unsigned EVT_MASK_MSB = 4;

    localparam int unsigned EVT_SW_W   = EVT_SW_MSB - EVT_SW_LSB + 1;
    localparam int unsigned EVT_MASK_W = EVT_MASK_MSB + 1;
    localparam int unsigned EVT_RSVD_W = EVT_SW_LSB - EVT_MASK_W;

    typedef struct packed {
        logic [EVT_SW_W-1:0]   sw;
        logic [EVT_RSVD_W-1:0] rsvd;
        logic [EVT_MASK_W-1:0] mask;
    } event_t;

endpackage

// File: rtl/debounce_cell.sv
// One input channel: two-flop synchronizer followed by a stability counter.
// The debounced level only follows the synchronized input after DEBOUNCE_CYCLES stable cycles.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw,
    output logic db
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0_q;
    logic             sync1_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync0_q <= raw;
            sync1_q <= sync0_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // Any return to the current level restarts the count, so short glitches never land.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync1_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = sync1_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/gpio_input_ctrl.sv
// Board input controller: debounces switches/buttons and queues one event word per press
// into a small FIFO drained by the consumer over a valid/ready handshake.
module gpio_input_ctrl
    import gpio_in_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned BTN_WIDTH       = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [SW_WIDTH-1:0]           SW,
    input  logic [BTN_WIDTH-1:0]          BTN,
    input  logic                          rd_ready,
    input  logic                          clr_ovf,
    output logic                          rd_valid,
    output logic [EVT_WORD_W-1:0]         rd_data,
    output logic [SW_WIDTH-1:0]           sw_level,
    output logic [$clog2(FIFO_DEPTH):0]   event_count,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [SW_WIDTH-1:0]  sw_db;
    logic [BTN_WIDTH-1:0] btn_db;
    logic [BTN_WIDTH-1:0] btn_db_q;
    logic [BTN_WIDTH-1:0] press_mask;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk  (clk),
            .n_rst(n_rst),
            .raw  (SW[i]),
            .db   (sw_db[i])
        );
    end

    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk  (clk),
            .n_rst(n_rst),
            .raw  (BTN[i]),
            .db   (btn_db[i])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            btn_db_q <= '0;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    // Rising edges of the debounced buttons only; releases are ignored.
    assign press_mask = btn_db & ~btn_db_q;

    event_t push_word;

    always_comb begin
        push_word      = '0;
        push_word.sw   = EVT_SW_W'(sw_db);
        push_word.mask = EVT_MASK_W'(press_mask);
    end

    // Event FIFO
    event_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             rd_valid_q;
    logic             rd_valid_d;
    event_t           rd_data_q;
    event_t           rd_data_d;

    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    assign push  = |press_mask;
    assign pop   = rd_valid_q & rd_ready;
    assign full  = (count_q == FULL_COUNT);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Registered head: reloads one cycle after occupancy appears, with a bubble after each pop
    // so the popped word is never presented twice.
    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (pop) begin
            rd_valid_d = 1'b0;
        end else if (count_q != '0) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem[rd_ptr_q];
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign sw_level    = sw_db;
    assign event_count = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Directed bench for gpio_input_ctrl with DEBOUNCE_CYCLES=4 and an 8-entry FIFO.
module tb_gpio_input_ctrl;

    logic        clk;
    logic        n_rst;
    logic [15:0] SW;
    logic [4:0]  BTN;
    logic        rd_ready;
    logic        clr_ovf;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [15:0] sw_level;
    logic [3:0]  event_count;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q [9];
    logic [31:0] exp_word;

    gpio_input_ctrl #(
        .SW_WIDTH       (16),
        .BTN_WIDTH      (5),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .SW         (SW),
        .BTN        (BTN),
        .rd_ready   (rd_ready),
        .clr_ovf    (clr_ovf),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .sw_level   (sw_level),
        .event_count(event_count),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] word(input logic [15:0] s, input logic [4:0] m);
        return {s, 11'b0, m};
    endfunction

    task automatic press(input logic [4:0] m);
        BTN = m;
        step(8);
        BTN = '0;
        step(8);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (rd_valid !== 1'b1 && n < 10) begin
            step(1);
            n++;
        end
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
    endtask

    initial begin
        n_rst    = 1'b0;
        SW       = 16'hFFFF;
        BTN      = 5'h1F;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        step(3);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_sw_level", 32'(sw_level), 32'h0);
        chk("rst_event_count", 32'(event_count), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);

        // Release reset; switch levels appear exactly 2+4 clocks later.
        n_rst = 1'b1;
        BTN   = '0;
        step(5);
        chk("sw_latency_early", 32'(sw_level), 32'h0);
        step(1);
        chk("sw_latency_exact", 32'(sw_level), 32'hFFFF);

        // Glitch rejection: 3-clock pulse.
        SW = 16'hA5A5;
        step(8);
        chk("sw_a5a5", 32'(sw_level), 32'hA5A5);
        BTN = 5'h01;
        step(3);
        BTN = '0;
        step(10);
        chk("glitch_rd_valid", 32'(rd_valid), 32'h0);
        chk("glitch_count", 32'(event_count), 32'h0);

        // Real press held 10 clocks: rd_valid rises 8 clocks after the raw edge.
        BTN = 5'h01;
        step(7);
        chk("press_valid_early", 32'(rd_valid), 32'h0);
        chk("press_count_written", 32'(event_count), 32'h1);
        step(1);
        chk("press_valid_exact", 32'(rd_valid), 32'h1);
        chk("press_word", rd_data, 32'hA5A5_0001);
        step(2);
        BTN = '0;
        step(10);
        chk("release_no_event", 32'(event_count), 32'h1);
        pop_one();
        chk("pop_count", 32'(event_count), 32'h0);
        chk("pop_valid", 32'(rd_valid), 32'h0);

        // Simultaneous presses.
        BTN = 5'b01010;
        step(8);
        chk("simul_valid", 32'(rd_valid), 32'h1);
        chk("simul_word", rd_data, 32'hA5A5_000A);
        BTN = '0;
        step(10);
        chk("simul_release", 32'(event_count), 32'h1);
        pop_one();
        step(3);
        chk("simul_drained", 32'(event_count), 32'h0);

        // Nine presses into an 8-deep FIFO without reading.
        for (int i = 0; i < 9; i++) begin
            logic [4:0] m;
            SW = 16'h0100 + 16'(i);
            step(8);
            m = 5'(1 << (i % 5));
            exp_q[i] = word(16'h0100 + 16'(i), m);
            press(m);
        end
        chk("ovf_count", 32'(event_count), 32'h8);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_head", rd_data, exp_q[0]);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Full FIFO: pop coincides with the push edge (edge 7 after the raw edge).
        SW = 16'hBEEF;
        step(8);
        BTN = 5'h10;
        step(6);
        chk("full_head_before", rd_data, exp_q[0]);
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
        BTN = '0;
        chk("full_pop_count", 32'(event_count), 32'h8);
        chk("full_pop_ovf", 32'(overflow), 32'h0);
        step(10);

        for (int k = 0; k < 8; k++) begin
            exp_word = (k < 7) ? exp_q[k + 1] : 32'hBEEF_0010;
            wait_valid();
            chk($sformatf("drain_valid_%0d", k), 32'(rd_valid), 32'h1);
            chk($sformatf("drain_word_%0d", k), rd_data, exp_word);
            pop_one();
        end
        step(3);
        chk("drain_empty", 32'(event_count), 32'h0);

        // Async reset with five queued events.
        SW = 16'h5A5A;
        step(8);
        press(5'h01);
        press(5'h02);
        press(5'h04);
        press(5'h08);
        press(5'h10);
        chk("queued_five", 32'(event_count), 32'h5);
        n_rst = 1'b0;
        #1;
        chk("async_rd_valid", 32'(rd_valid), 32'h0);
        chk("async_count", 32'(event_count), 32'h0);
        chk("async_sw_level", 32'(sw_level), 32'h0);
        #3;
        n_rst = 1'b1;
        step(20);
        chk("post_rst_valid", 32'(rd_valid), 32'h0);
        chk("post_rst_count", 32'(event_count), 32'h0);
        chk("post_rst_ovf", 32'(overflow), 32'h0);
        chk("post_rst_sw", 32'(sw_level), 32'h5A5A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
